// File: rtl/boot_source_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// boot_source_sequencer_pkg
//   Shared encodings for the boot source sequencer: opcode field geometry,
//   the HALT opcode, the NOP word and the sequencer state type.
// ---------------------------------------------------------------------------
package boot_source_sequencer_pkg;

  // Opcode occupies the top OPCODE_W bits of the instruction word.
  localparam int unsigned OPCODE_W = 6;

  // Opcode that terminates a boot stage.
  localparam logic [OPCODE_W-1:0] HALT_OPCODE = 6'b111111;

  // Instruction word fed to the CPU while a source switch is in progress.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // RUN forwards the selected source; PULSE holds the CPU in reset.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_PULSE = 1'b1
  } seq_state_e;

endpackage : boot_source_sequencer_pkg

// File: rtl/boot_source_sequencer_source_mux.sv
// ---------------------------------------------------------------------------
// boot_source_sequencer_source_mux
//   NUM_SRC-to-1 instruction word multiplexer.
//   Ports:
//     src_i  : flattened source words, source i at [i*DATA_W +: DATA_W]
//     sel_i  : source index
//     word_o : selected word (zero for out-of-range indices)
// ---------------------------------------------------------------------------
module boot_source_sequencer_source_mux
  import boot_source_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned SEL_W   = 1
) (
  input  logic [NUM_SRC*DATA_W-1:0] src_i,
  input  logic [SEL_W-1:0]          sel_i,
  output logic [DATA_W-1:0]         word_o
);

  always_comb begin
    word_o = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (sel_i == SEL_W'(i)) begin
        word_o = src_i[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule : boot_source_sequencer_source_mux

// File: rtl/boot_source_sequencer.sv
// ---------------------------------------------------------------------------
// boot_source_sequencer
//   Selects which instruction source (BIOS ROM, main memory, further images)
//   feeds the fetch stage. A HALT opcode from a non-final source advances to
//   the next source and holds the CPU in reset for RESET_CYCLES cycles while
//   NOPs are fed; a return request re-boots from source 0.
//
//   Optional build macro: BOOT_TIMEOUT_EN
//     Adds a boot watchdog on source 0 and the sticky boot_fail output.
//
//   Ports:
//     clk         : system clock
//     reset       : asynchronous, active-high reset
//     src_instr   : flattened source words, source i at [i*DATA_W +: DATA_W]
//     instr_valid : fetch presents a real instruction this cycle
//     ret_req     : single-cycle request to return to source 0
//     instr_out   : instruction word to the CPU
//     src_sel     : active source index
//     cpu_reset   : registered reset to the CPU/PC
//     switch_busy : high while the reset pulse is in progress (fetch stalls)
//     boot_fail   : sticky watchdog flag (BOOT_TIMEOUT_EN only)
// ---------------------------------------------------------------------------
module boot_source_sequencer
  import boot_source_sequencer_pkg::*;
#(
  parameter int unsigned        DATA_W       = 32,
  parameter int unsigned        NUM_SRC      = 2,
  parameter logic [OPCODE_W-1:0] HALT_OP     = HALT_OPCODE,
  parameter int unsigned        RESET_CYCLES = 1,
  parameter logic [DATA_W-1:0]  NOP_INSTR    = DATA_W'(NOP_WORD),
  parameter int unsigned        TIMEOUT      = 65535,
  localparam int unsigned       SEL_W        = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*DATA_W-1:0] src_instr,
  input  logic                      instr_valid,
  input  logic                      ret_req,
  output logic [DATA_W-1:0]         instr_out,
  output logic [SEL_W-1:0]          src_sel,
  output logic                      cpu_reset,
  output logic                      switch_busy
`ifdef BOOT_TIMEOUT_EN
  ,
  output logic                      boot_fail
`endif
);

  localparam int unsigned CNT_W = $clog2(RESET_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(RESET_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_SRC - 1);
  localparam bit PARAMS_OK = (NUM_SRC >= 2) && (RESET_CYCLES >= 1) &&
                             (TIMEOUT >= 1) && (DATA_W >= OPCODE_W);

  if (!PARAMS_OK) begin : g_param_check
    $error("boot_source_sequencer: illegal parameter combination");
  end

  seq_state_e        state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic [DATA_W-1:0] mux_word;
  logic              halt_hit;

  boot_source_sequencer_source_mux #(
    .DATA_W  (DATA_W),
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_source_mux (
    .src_i  (src_instr),
    .sel_i  (sel_q),
    .word_o (mux_word)
  );

  // A HALT on the last source is not a switch: it reaches the CPU untouched.
  assign halt_hit = (state_q == ST_RUN) && instr_valid &&
                    (mux_word[DATA_W-1 -: OPCODE_W] == HALT_OP) &&
                    (sel_q < SEL_LAST);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    cpu_reset_d = cpu_reset_q;
    instr_out   = mux_word;
    switch_busy = 1'b0;

    if (state_q == ST_PULSE) begin
      instr_out   = NOP_INSTR;
      switch_busy = 1'b1;
    end

    // Return request overrides everything, including a pulse in progress.
    if (ret_req) begin
      sel_d       = '0;
      state_d     = ST_PULSE;
      cnt_d       = CNT_RELOAD;
      cpu_reset_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (halt_hit) begin
            sel_d       = sel_q + 1'b1;
            state_d     = ST_PULSE;
            cnt_d       = CNT_RELOAD;
            cpu_reset_d = 1'b1;
          end
        end
        ST_PULSE: begin
          if (cnt_q == '0) begin
            state_d     = ST_RUN;
            cpu_reset_d = 1'b0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d     = ST_RUN;
          cpu_reset_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      sel_q       <= '0;
      cnt_q       <= '0;
      cpu_reset_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      cpu_reset_q <= cpu_reset_d;
    end
  end

  assign src_sel   = sel_q;
  assign cpu_reset = cpu_reset_q;

`ifdef BOOT_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            fail_q, fail_d;

  // Counts RUN cycles on source 0; any other situation clears it.
  // Saturates at TIMEOUT; the flag is raised on the edge the limit is reached.
  always_comb begin
    wd_d   = wd_q;
    fail_d = fail_q;
    if ((state_q == ST_RUN) && (sel_q == '0)) begin
      if (wd_q != WD_LIMIT) begin
        wd_d = wd_q + 1'b1;
      end
    end else begin
      wd_d = '0;
    end
    if (wd_d == WD_LIMIT) begin
      fail_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q   <= '0;
      fail_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      fail_q <= fail_d;
    end
  end

  assign boot_fail = fail_q;
`endif

endmodule : boot_source_sequencer

// File: tb/tb_boot_source_sequencer.sv
// ---------------------------------------------------------------------------
// tb_boot_source_sequencer
//   Directed scoreboard bench: NUM_SRC=3, RESET_CYCLES=3, TIMEOUT=10.
//   Each stimulus step pushes the hand-computed response for its cycle; a
//   monitor pops and compares on every falling edge.
// ---------------------------------------------------------------------------
module tb_boot_source_sequencer;

  localparam int unsigned DW = 32;
  localparam int unsigned NS = 3;
  localparam int unsigned SW = 2;

  localparam logic [31:0] S0 = 32'h2001_0005;
  localparam logic [31:0] S1 = 32'h1234_5678;
  localparam logic [31:0] S2 = 32'hCAFE_0002;
  localparam logic [31:0] H  = 32'hFC00_0000;
  localparam logic [31:0] N  = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              reset;
  logic [NS*DW-1:0]  src_instr;
  logic              instr_valid;
  logic              ret_req;
  logic [DW-1:0]     instr_out;
  logic [SW-1:0]     src_sel;
  logic              cpu_reset;
  logic              switch_busy;
`ifdef BOOT_TIMEOUT_EN
  logic              boot_fail;
`endif

  typedef struct {
    string       name;
    logic [31:0] out;
    logic [1:0]  sel;
    logic        rst;
    logic        busy;
    logic        chk_bf;
    logic        bf;
  } exp_t;

  exp_t        sbq[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  boot_source_sequencer #(
    .DATA_W       (DW),
    .NUM_SRC      (NS),
    .RESET_CYCLES (3),
    .TIMEOUT      (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .src_instr   (src_instr),
    .instr_valid (instr_valid),
    .ret_req     (ret_req),
    .instr_out   (instr_out),
    .src_sel     (src_sel),
    .cpu_reset   (cpu_reset),
    .switch_busy (switch_busy)
`ifdef BOOT_TIMEOUT_EN
    ,
    .boot_fail   (boot_fail)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
  endtask

  // Drive one cycle of inputs just after the rising edge and queue the
  // response expected before the next rising edge.
  task automatic step(input logic rst, input logic [31:0] s0, input logic [31:0] s1,
                      input logic [31:0] s2, input logic v, input logic r,
                      input string nm, input logic [31:0] eo, input logic [1:0] es,
                      input logic er, input logic eb, input logic cb, input logic ebf);
    exp_t e;
    @(posedge clk);
    #1;
    reset       = rst;
    src_instr   = {s2, s1, s0};
    instr_valid = v;
    ret_req     = r;
    e.name = nm; e.out = eo; e.sel = es; e.rst = er; e.busy = eb;
    e.chk_bf = cb; e.bf = ebf;
    sbq.push_back(e);
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        chk({e.name, ".instr_out"},   instr_out, e.out);
        chk({e.name, ".src_sel"},     32'(src_sel), 32'(e.sel));
        chk({e.name, ".cpu_reset"},   32'(cpu_reset), 32'(e.rst));
        chk({e.name, ".switch_busy"}, 32'(switch_busy), 32'(e.busy));
`ifdef BOOT_TIMEOUT_EN
        if (e.chk_bf) chk({e.name, ".boot_fail"}, 32'(boot_fail), 32'(e.bf));
`endif
      end
    end
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1; src_instr = '0; instr_valid = 1'b0; ret_req = 1'b0;
    //    rst  s0  s1  s2  v  r  name                 out sel rst busy cb bf
    step(1'b1, S0, S1, S2, 0, 0, "reset",             S0, 0, 0, 0, 0, 0);
    step(1'b0, S0, S1, S2, 1, 0, "run_src0",          S0, 0, 0, 0, 0, 0);
    step(1'b0, H,  S1, S2, 0, 0, "halt_novalid",      H,  0, 0, 0, 0, 0);
    step(1'b0, H,  S1, S2, 1, 0, "halt_src0",         H,  0, 0, 0, 0, 0);
    // HALT presented on the new source during the pulse must be ignored
    step(1'b0, S0, H,  S2, 1, 0, "pulse01_c1",        N,  1, 1, 1, 0, 0);
    step(1'b0, S0, S1, S2, 1, 0, "pulse01_c2",        N,  1, 1, 1, 0, 0);
    step(1'b0, S0, S1, S2, 1, 0, "pulse01_c3",        N,  1, 1, 1, 0, 0);
    step(1'b0, S0, S1, S2, 1, 0, "run_src1",          S1, 1, 0, 0, 0, 0);
    step(1'b0, S0, H,  S2, 1, 0, "halt_src1",         H,  1, 0, 0, 0, 0);
    step(1'b0, S0, S1, S2, 1, 0, "pulse12_c1",        N,  2, 1, 1, 0, 0);
    step(1'b0, S0, S1, S2, 1, 0, "pulse12_c2",        N,  2, 1, 1, 0, 0);
    step(1'b0, S0, S1, S2, 1, 0, "pulse12_c3",        N,  2, 1, 1, 0, 0);
    step(1'b0, S0, S1, H,  1, 0, "halt_last",         H,  2, 0, 0, 0, 0);
    step(1'b0, S0, S1, H,  1, 0, "halt_last_hold",    H,  2, 0, 0, 0, 0);
    step(1'b0, S0, S1, S2, 1, 1, "ret_issue",         S2, 2, 0, 0, 0, 0);
    // ret_req again in the 1st pulse cycle: sampled at the edge opening the
    // 2nd cycle, so the pulse restarts and cpu_reset stays high 4 cycles
    step(1'b0, S0, S1, S2, 1, 1, "ret_pulse_c1",      N,  0, 1, 1, 0, 0);
    step(1'b0, S0, S1, S2, 1, 0, "ret_pulse_c2",      N,  0, 1, 1, 0, 0);
    step(1'b0, S0, S1, S2, 1, 0, "ret_pulse_c3",      N,  0, 1, 1, 0, 0);
    step(1'b0, S0, S1, S2, 1, 0, "ret_pulse_c4",      N,  0, 1, 1, 0, 0);
    step(1'b0, S0, S1, S2, 1, 0, "run_after_ret",     S0, 0, 0, 0, 0, 0);
    step(1'b0, H,  S1, S2, 1, 0, "halt_src0_b",       H,  0, 0, 0, 0, 0);
    step(1'b0, S0, S1, S2, 1, 0, "pulse01b_c1",       N,  1, 1, 1, 0, 0);
    step(1'b0, S0, S1, S2, 1, 0, "pulse01b_c2",       N,  1, 1, 1, 0, 0);
    step(1'b0, S0, S1, S2, 1, 0, "pulse01b_c3",       N,  1, 1, 1, 0, 0);
    step(1'b0, S0, H,  S2, 1, 1, "halt_and_ret",      H,  1, 0, 0, 0, 0);
    step(1'b0, S0, S1, S2, 1, 0, "retwin_c1",         N,  0, 1, 1, 0, 0);
    step(1'b0, S0, S1, S2, 1, 0, "retwin_c2",         N,  0, 1, 1, 0, 0);
    step(1'b0, S0, S1, S2, 1, 0, "retwin_c3",         N,  0, 1, 1, 0, 0);
    step(1'b0, S0, S1, S2, 1, 0, "run_after_retwin",  S0, 0, 0, 0, 0, 0);
    step(1'b0, H,  S1, S2, 1, 0, "halt_before_abort", H,  0, 0, 0, 0, 0);
    // Reset raised right after the switch edge aborts the pulse at once
    step(1'b1, S0, S1, S2, 1, 0, "reset_midpulse",    S0, 0, 0, 0, 0, 0);
    step(1'b0, S0, S1, S2, 0, 0, "after_abort",       S0, 0, 0, 0, 0, 0);

    // Watchdog phase: boot_fail rises on the 10th edge after reset release
    step(1'b1, S0, S1, S2, 0, 0, "wd_reset",          S0, 0, 0, 0, 1, 0);
    step(1'b0, S0, S1, S2, 0, 0, "wd_release",        S0, 0, 0, 0, 1, 0);
    for (int j = 1; j <= 9; j++) begin
      step(1'b0, S0, S1, S2, 0, 0, $sformatf("wd_count%0d", j), S0, 0, 0, 0, 1, 0);
    end
    step(1'b0, S0, S1, S2, 0, 0, "wd_expire",         S0, 0, 0, 0, 1, 1);
    step(1'b0, H,  S1, S2, 1, 0, "wd_halt",           H,  0, 0, 0, 1, 1);
    step(1'b0, S0, S1, S2, 1, 0, "wd_pulse_c1",       N,  1, 1, 1, 1, 1);
    step(1'b0, S0, S1, S2, 1, 0, "wd_pulse_c2",       N,  1, 1, 1, 1, 1);
    step(1'b0, S0, S1, S2, 1, 0, "wd_pulse_c3",       N,  1, 1, 1, 1, 1);
    step(1'b0, S0, S1, S2, 1, 0, "wd_sticky_src1",    S1, 1, 0, 0, 1, 1);
    step(1'b1, S0, S1, S2, 0, 0, "wd_reset_clear",    S0, 0, 0, 0, 1, 0);
    step(1'b0, S0, S1, S2, 0, 0, "wd_after_clear",    S0, 0, 0, 0, 1, 0);

    // Let the monitor drain, bounded
    for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clk);
    @(posedge clk);
    if (sbq.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending entries, expected 0", sbq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_boot_source_sequencer
